// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared constants and types for the micro CPU controller
// Contents:
//   CMD_*    ALU command codes, shared with MCPU_Alu
//   CLS_*    instruction class codes (instruction bits [7:6])
//   state_t  controller FSM state encoding
package mcpu_pkg;

  localparam logic [1:0] CMD_AND = 2'd0;
  localparam logic [1:0] CMD_OR  = 2'd1;
  localparam logic [1:0] CMD_XOR = 2'd2;
  localparam logic [1:0] CMD_ADD = 2'd3;

  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_LDI  = 2'd1;
  localparam logic [1:0] CLS_JMP  = 2'd2;
  localparam logic [1:0] CLS_HALT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_FETCH_IMM,
    S_HALT
  } state_t;

endpackage

// File: rtl/mcpu_regfile.sv
// rtl/mcpu_regfile.sv - 2^NREGS_LOG2 x WORD_SIZE register file for the micro CPU
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset (clears all regs)
//   we/waddr/wdata     single synchronous write port
//   a_addr/a_data      combinational read port (rd operand)
//   b_addr/b_data      combinational read port (rs operand)
//   dbg_addr/dbg_data  combinational read port (debug)
module mcpu_regfile #(
  parameter int WORD_SIZE  = 8,
  parameter int NREGS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [NREGS_LOG2-1:0] waddr,
  input  logic [WORD_SIZE-1:0]  wdata,
  input  logic [NREGS_LOG2-1:0] a_addr,
  output logic [WORD_SIZE-1:0]  a_data,
  input  logic [NREGS_LOG2-1:0] b_addr,
  output logic [WORD_SIZE-1:0]  b_data,
  input  logic [NREGS_LOG2-1:0] dbg_addr,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  localparam int NREGS = 1 << NREGS_LOG2;

  logic [WORD_SIZE-1:0] regs [NREGS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign a_data   = regs[a_addr];
  assign b_data   = regs[b_addr];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multicycle fetch/decode/execute controller for the micro CPU
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   imem_req/imem_addr    instruction fetch request and address (= PC)
//   imem_rdata/imem_valid fetched word and its valid strobe
//   alu_opcode/r1/r2      command and operands to MCPU_Alu (reg[rd], reg[rs])
//   alu_out/alu_overflow  result and carry from MCPU_Alu
//   halted                high while in HALT
//   ovf_flag              registered overflow flag
//   dbg_sel/dbg_data      debug register read
// Instruction word: [7:6] class, [5:4] cmd, [3:2] rd, [1:0] rs.
module mcpu_ctrl
  import mcpu_pkg::*;
#(
  parameter int CMD_SIZE   = 2,
  parameter int WORD_SIZE  = 8,
  parameter int PC_SIZE    = 8,
  parameter int NREGS_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [PC_SIZE-1:0]    imem_addr,
  input  logic [WORD_SIZE-1:0]  imem_rdata,
  input  logic                  imem_valid,
  output logic [CMD_SIZE-1:0]   alu_opcode,
  output logic [WORD_SIZE-1:0]  alu_r1,
  output logic [WORD_SIZE-1:0]  alu_r2,
  input  logic [WORD_SIZE-1:0]  alu_out,
  input  logic                  alu_overflow,
  output logic                  halted,
  output logic                  ovf_flag,
  input  logic [NREGS_LOG2-1:0] dbg_sel,
  output logic [WORD_SIZE-1:0]  dbg_data
);

  state_t                state, state_n;
  logic [PC_SIZE-1:0]    pc, pc_n;
  logic [WORD_SIZE-1:0]  ir, ir_n;
  logic                  ovf_n;
  logic                  rf_we;
  logic [WORD_SIZE-1:0]  rf_wdata;

  logic [1:0]            ir_cls;
  logic [NREGS_LOG2-1:0] ir_rd;
  logic [NREGS_LOG2-1:0] ir_rs;

  assign ir_cls = ir[7:6];
  assign ir_rd  = ir[2 +: NREGS_LOG2];
  assign ir_rs  = ir[0 +: NREGS_LOG2];

  // Operands are decoded from IR in every state; only EXEC consumes them.
  assign alu_opcode = ir[4 +: CMD_SIZE];
  assign imem_addr  = pc;

  mcpu_regfile #(
    .WORD_SIZE  (WORD_SIZE),
    .NREGS_LOG2 (NREGS_LOG2)
  ) u_regfile (
    .clk      (clk),
    .reset    (reset),
    .we       (rf_we),
    .waddr    (ir_rd),
    .wdata    (rf_wdata),
    .a_addr   (ir_rd),
    .a_data   (alu_r1),
    .b_addr   (ir_rs),
    .b_data   (alu_r2),
    .dbg_addr (dbg_sel),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      ir       <= '0;
      ovf_flag <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      ir       <= ir_n;
      ovf_flag <= ovf_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    ir_n     = ir;
    ovf_n    = ovf_flag;
    rf_we    = 1'b0;
    rf_wdata = alu_out;
    imem_req = 1'b0;
    halted   = 1'b0;

    case (state)
      S_IDLE: begin
        state_n = S_FETCH;
      end

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_n    = imem_rdata;
          pc_n    = pc + PC_SIZE'(1);
          state_n = S_DECODE;
        end
      end

      S_DECODE: begin
        case (ir_cls)
          CLS_ALU:          state_n = S_EXEC;
          CLS_LDI, CLS_JMP: state_n = S_FETCH_IMM;
          default:          state_n = S_HALT;
        endcase
      end

      S_EXEC: begin
        rf_we    = 1'b1;
        rf_wdata = alu_out;
        ovf_n    = alu_overflow;
        state_n  = S_FETCH;
      end

      S_FETCH_IMM: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          pc_n    = pc + PC_SIZE'(1);
          state_n = S_FETCH;
          if (ir_cls == CLS_LDI) begin
            rf_we    = 1'b1;
            rf_wdata = imem_rdata;
          end else if (!ir[0] || ovf_flag) begin
            // ir[0] selects the overflow-conditional jump; a taken jump
            // replaces the post-immediate increment.
            pc_n = imem_rdata[PC_SIZE-1:0];
          end
        end
      end

      S_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - self-checking bench for mcpu_ctrl with memory, ALU and ISS models
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata = 8'h00;
  logic       imem_valid = 1'b0;
  logic [1:0] alu_opcode;
  logic [7:0] alu_r1, alu_r2;
  logic [7:0] alu_out;
  logic       alu_overflow;
  logic       halted;
  logic       ovf_flag;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_data;

  mcpu_ctrl #(.CMD_SIZE(2), .WORD_SIZE(8), .PC_SIZE(8), .NREGS_LOG2(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .alu_opcode   (alu_opcode),
    .alu_r1       (alu_r1),
    .alu_r2       (alu_r2),
    .alu_out      (alu_out),
    .alu_overflow (alu_overflow),
    .halted       (halted),
    .ovf_flag     (ovf_flag),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  // MCPU_Alu model
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum      = {1'b0, alu_r1} + {1'b0, alu_r2};
    alu_overflow = 1'b0;
    case (alu_opcode)
      2'd0:    alu_out = alu_r1 & alu_r2;
      2'd1:    alu_out = alu_r1 | alu_r2;
      2'd2:    alu_out = alu_r1 ^ alu_r2;
      default: begin
        alu_out      = alu_sum[7:0];
        alu_overflow = alu_sum[8];
      end
    endcase
  end

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction memory with programmable wait states
  logic [7:0] mem [256];
  int         wait_n      = 0;
  int         cnt         = 0;
  logic       force_valid = 1'b0;
  logic       sb_en       = 1'b0;
  int         stab_err    = 0;
  logic [7:0] hold_addr   = 8'h00;
  logic [7:0] exp_q [$];

  initial begin
    forever begin
      @(negedge clk);
      if (imem_valid) cnt = 0;
      if (force_valid) begin
        imem_valid = 1'b1;
        imem_rdata = mem[imem_addr];
      end else if (reset || !imem_req) begin
        if (!reset && cnt != 0) stab_err++;
        imem_valid = 1'b0;
        cnt        = 0;
      end else begin
        if (cnt == 0) hold_addr = imem_addr;
        else if (imem_addr !== hold_addr) stab_err++;
        if (cnt == wait_n) begin
          imem_valid = 1'b1;
          imem_rdata = mem[imem_addr];
          if (sb_en) begin
            if (exp_q.size() == 0) chk("sb_extra_fetch", {24'h0, imem_addr}, 32'hFFFF_FFFF);
            else chk("sb_fetch_addr", {24'h0, imem_addr}, {24'h0, exp_q.pop_front()});
          end
        end else begin
          imem_valid = 1'b0;
          cnt++;
        end
      end
    end
  end

  // Instruction-level model: produces the expected sequence of fetch addresses.
  task automatic iss();
    logic [7:0] pc, ins, t, a, b;
    logic [7:0] r [4];
    logic [8:0] s;
    logic       ov, done;
    exp_q.delete();
    pc = 8'h00; ov = 1'b0; done = 1'b0;
    for (int i = 0; i < 4; i++) r[i] = 8'h00;
    for (int step = 0; step < 300 && !done; step++) begin
      exp_q.push_back(pc);
      ins = mem[pc];
      pc  = pc + 8'd1;
      a   = r[ins[3:2]];
      b   = r[ins[1:0]];
      case (ins[7:6])
        2'b00: begin
          ov = 1'b0;
          case (ins[5:4])
            2'd0: r[ins[3:2]] = a & b;
            2'd1: r[ins[3:2]] = a | b;
            2'd2: r[ins[3:2]] = a ^ b;
            default: begin
              s = {1'b0, a} + {1'b0, b};
              r[ins[3:2]] = s[7:0];
              ov = s[8];
            end
          endcase
        end
        2'b01: begin
          exp_q.push_back(pc);
          r[ins[3:2]] = mem[pc];
          pc = pc + 8'd1;
        end
        2'b10: begin
          exp_q.push_back(pc);
          t  = mem[pc];
          pc = pc + 8'd1;
          if (!ins[0] || ov) pc = t;
        end
        default: done = 1'b1;
      endcase
    end
  endtask

  typedef struct {
    string       name;
    logic [95:0] prog;
    logic [7:0]  p_addr;
    logic [7:0]  p_data;
    int          waits;
    logic [31:0] exp_regs;
    logic        exp_ovf;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  task automatic load(input logic [95:0] prog, input logic [7:0] pa, input logic [7:0] pd);
    for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
    for (int i = 0; i < 12; i++) mem[i] = prog[95 - 8*i -: 8];
    mem[pa] = pd;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_regs(input string pfx, input logic [31:0] exp);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = r[1:0];
      #1;
      chk($sformatf("%s_r%0d", pfx, r), {24'h0, dbg_data}, {24'h0, exp[8*r +: 8]});
    end
  endtask

  task automatic wait_halt(input string pfx);
    logic seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      seen = halted;
    end
    chk({pfx, "_halted"}, {31'h0, seen}, 32'h1);
  endtask

  task automatic wait_fetch_at(input logic [7:0] a);
    logic seen = 1'b0;
    for (int c = 0; c < 500 && !seen; c++) begin
      @(negedge clk);
      seen = imem_req && (imem_addr == a);
    end
    chk($sformatf("reach_fetch_%0h", a), {31'h0, seen}, 32'h1);
  endtask

  localparam logic [95:0] PROG1 = 96'h40_02_44_06_31_C0_C0C0C0C0C0C0;

  initial begin
    vecs[0] = '{"zero_wait",  PROG1, 8'h10, 8'hC0, 0, 32'h0000_0608, 1'b0};
    vecs[1] = '{"wait3",      PROG1, 8'h10, 8'hC0, 3, 32'h0000_0608, 1'b0};
    vecs[2] = '{"jmp_taken",  96'h48_FF_4C_01_3B_81_10_C0C0C0C0C0, 8'h10, 8'hC0, 0, 32'h0100_0000, 1'b1};
    vecs[3] = '{"jmp_nottkn", 96'h81_10_C0_C0C0C0C0C0C0C0C0C0,    8'h10, 8'h40, 0, 32'h0000_0000, 1'b0};
    vecs[4] = '{"pc_wrap",    96'h5A_80_80_FF_C0C0C0C0C0C0C0C0,    8'hFF, 8'h40, 0, 32'h0080_005A, 1'b0};
    vecs[5] = '{"or_clr_ovf", 96'h48_FF_4C_01_3B_1E_81_20_C0C0C0C0, 8'h20, 8'h40, 0, 32'h0100_0000, 1'b0};
    vecs[6] = '{"rd_eq_rs",   96'h40_81_30_44_07_C0_C0C0C0C0C0C0, 8'h40, 8'hC0, 2, 32'h0000_0702, 1'b1};

    // Reset state
    #1;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_ovf", {31'h0, ovf_flag}, 32'h0);
    chk("rst_alu_ops", {22'h0, alu_opcode, alu_r1, alu_r2}, 32'h0);
    chk_regs("rst", 32'h0);

    // Table-driven programs, fetch addresses scoreboarded against the ISS
    for (int v = 0; v < NV; v++) begin
      load(vecs[v].prog, vecs[v].p_addr, vecs[v].p_data);
      wait_n   = vecs[v].waits;
      stab_err = 0;
      iss();
      sb_en = 1'b1;
      do_reset();
      wait_halt(vecs[v].name);
      sb_en = 1'b0;
      chk_regs(vecs[v].name, vecs[v].exp_regs);
      chk({vecs[v].name, "_ovf"}, {31'h0, ovf_flag}, {31'h0, vecs[v].exp_ovf});
      chk({vecs[v].name, "_req_low"}, {31'h0, imem_req}, 32'h0);
      chk({vecs[v].name, "_sb_left"}, exp_q.size(), 32'h0);
      if (vecs[v].waits > 0) chk({vecs[v].name, "_req_addr_stable"}, stab_err, 32'h0);
    end

    // ADD latency: FETCH, DECODE, EXEC with writeback at the end of EXEC
    load(PROG1, 8'h10, 8'hC0);
    wait_n = 0;
    do_reset();
    dbg_sel = 2'd0;
    wait_fetch_at(8'h04);
    @(posedge clk); #1;
    chk("lat_decode_r0", {24'h0, dbg_data}, 32'h02);
    @(posedge clk); #1;
    chk("lat_exec_r0", {24'h0, dbg_data}, 32'h02);
    chk("lat_exec_alu", {22'h0, alu_opcode, alu_r1, alu_r2}, {22'h0, 2'd3, 8'h02, 8'h06});
    chk("lat_exec_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    chk("lat_wb_r0", {24'h0, dbg_data}, 32'h08);
    chk("lat_next_fetch", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h05});

    // Reset asserted during EXEC
    do_reset();
    wait_fetch_at(8'h04);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rexec_req", {31'h0, imem_req}, 32'h0);
    chk("rexec_pc", {24'h0, imem_addr}, 32'h0);
    chk("rexec_ovf", {31'h0, ovf_flag}, 32'h0);
    chk_regs("rexec", 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rexec_idle_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;
    chk("rexec_refetch", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h00});

    // Reset asserted during FETCH_IMM with imem_valid held high
    do_reset();
    wait_fetch_at(8'h03);
    #1;
    force_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("rimm_req", {31'h0, imem_req}, 32'h0);
    chk("rimm_pc", {24'h0, imem_addr}, 32'h0);
    chk_regs("rimm", 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rimm_idle", {23'h0, imem_req, imem_addr}, 32'h0);
    @(posedge clk); #1;
    chk("rimm_fetch0", {23'h0, imem_req, imem_addr}, {23'h0, 1'b1, 8'h00});
    @(posedge clk); #1;
    chk("rimm_accept0", {23'h0, imem_req, imem_addr}, {23'h0, 1'b0, 8'h01});
    force_valid = 1'b0;
    wait_halt("rimm");
    chk_regs("rimm_end", 32'h0000_0608);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
